// File: rtl/aes_pkg.sv
// Shared AES definitions: block/byte typedefs, FSM state encoding,
// forward S-box (plus inverse S-box when SUB_SHIFT_INV_EN is defined)
// and the ShiftRows byte permutations.
// Byte order: byte 0 is the MSB byte of a 128-bit state, column-major.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_BYTES   = 16;

    typedef logic [7:0]                   aes_byte_t;
    // Element k of the packed array is byte k, i.e. bits [127-8k -: 8].
    typedef logic [0:AES_BYTES-1][7:0]    aes_state_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        HOLD = 2'd2
    } stage_state_e;

    // Forward S-box, entry n at index n.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef SUB_SHIFT_INV_EN
    // Inverse S-box, entry n at index n.
    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
`endif

    // Row r rotates left by r columns: out[4c+r] = in[4((c+r) mod 4)+r].
    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t o;
        o = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(4*c + r)] = s[4'(4*((c + r) % 4) + r)];
            end
        end
        return o;
    endfunction

`ifdef SUB_SHIFT_INV_EN
    // Row r rotates right by r columns: out[4c+r] = in[4((c-r) mod 4)+r].
    function automatic aes_state_t inv_shift_rows(input aes_state_t s);
        aes_state_t o;
        o = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(4*c + r)] = s[4'(4*((c + 4 - r) % 4) + r)];
            end
        end
        return o;
    endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte S-box lookup.
// Ports: in_byte (byte to substitute), inv (only with SUB_SHIFT_INV_EN:
// 1 selects the inverse S-box), out_byte_c (substituted byte).
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
`ifdef SUB_SHIFT_INV_EN
    input  logic       inv,
`endif
    output logic [7:0] out_byte_c
);

    // Table lookup
    always_comb begin
`ifdef SUB_SHIFT_INV_EN
        out_byte_c = inv ? INV_SBOX[in_byte] : SBOX[in_byte];
`else
        out_byte_c = SBOX[in_byte];
`endif
    end

endmodule

// File: rtl/sub_shift_stage.sv
// Iterative SubBytes + ShiftRows stage of the AES round datapath.
// Substitutes SBOX_LANES bytes per cycle through shared S-boxes, applies
// ShiftRows while registering the result and holds it until taken.
// Optional macro SUB_SHIFT_INV_EN adds the inv input (captured at accept)
// selecting InvSubBytes + InvShiftRows.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     upstream handshake (in_ready is combinational)
//   in_data, in_last      128-bit state and final-round flag
//   out_valid/out_ready   downstream handshake
//   out_data, out_last    ShiftRows(SubBytes(in_data)) and captured flag
//   busy                  high while in SUB or HOLD
module sub_shift_stage
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   in_last,
`ifdef SUB_SHIFT_INV_EN
    input  logic                   inv,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned NCHUNK = AES_BYTES / SBOX_LANES;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

    stage_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    aes_state_t       w_q, w_d;
    logic             last_q, last_d;
    logic             out_valid_q, out_valid_d;
    aes_state_t       out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
`ifdef SUB_SHIFT_INV_EN
    logic             inv_q, inv_d;
`endif

    aes_state_t       w_sub_c;
    aes_state_t       result_c;
    aes_byte_t        lane_in_c  [SBOX_LANES];
    aes_byte_t        lane_out_c [SBOX_LANES];
    logic             accept_c;

    // Byte position handled by lane l in chunk c
    function automatic logic [3:0] lane_byte(input logic [CNT_W-1:0] c,
                                             input int unsigned l);
        return 4'(32'(c) * SBOX_LANES + l);
    endfunction

    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept_c  = in_valid && in_ready;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // Route the current chunk of W into the S-box lanes
    always_comb begin
        for (int unsigned l = 0; l < SBOX_LANES; l++) begin
            lane_in_c[l] = w_q[lane_byte(cnt_q, l)];
        end
    end

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        aes_sbox u_sbox (
            .in_byte    (lane_in_c[g]),
`ifdef SUB_SHIFT_INV_EN
            .inv        (inv_q),
`endif
            .out_byte_c (lane_out_c[g])
        );
    end

    // W with the current chunk substituted, and its row-shifted form
    always_comb begin
        w_sub_c = w_q;
        for (int unsigned l = 0; l < SBOX_LANES; l++) begin
            w_sub_c[lane_byte(cnt_q, l)] = lane_out_c[l];
        end
`ifdef SUB_SHIFT_INV_EN
        result_c = inv_q ? inv_shift_rows(w_sub_c) : shift_rows(w_sub_c);
`else
        result_c = shift_rows(w_sub_c);
`endif
    end

    // Next-state and output-register logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_d         = w_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
`ifdef SUB_SHIFT_INV_EN
        inv_d       = inv_q;
`endif

        case (state_q)
            IDLE: ;
            SUB: begin
                w_d = w_sub_c;
                if (cnt_q == CNT_LAST) begin
                    out_data_d  = result_c;
                    out_last_d  = last_q;
                    out_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept covers both IDLE and the HOLD hand-off edge
        if (accept_c) begin
            w_d     = in_data;
            last_d  = in_last;
            cnt_d   = '0;
            state_d = SUB;
`ifdef SUB_SHIFT_INV_EN
            inv_d   = inv;
`endif
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            w_q         <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
`ifdef SUB_SHIFT_INV_EN
            inv_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            w_q         <= w_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
`ifdef SUB_SHIFT_INV_EN
            inv_q       <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_sub_shift_stage.sv
// Scoreboard bench for sub_shift_stage: the driver pushes expected results
// (data, last flag, cycle of first out_valid) and a monitor compares them
// whenever the DUT presents an output. Two extra instances cover
// SBOX_LANES=1 and 16.
module tb_sub_shift_stage;

    localparam int unsigned NCH = 4;

    localparam logic [127:0] ZERO_IN  = 128'h0;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};
    localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] APPB_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] SEQ_IN   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SEQ_OUT  = 128'h63fcac161bee28c3c4c193f54b8233ea;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_last;
    logic         out_valid, out_ready, out_last, busy;
    logic [127:0] in_data, out_data;
`ifdef SUB_SHIFT_INV_EN
    logic         inv;
`endif

    logic         s_valid;
    logic [127:0] s_data;
    logic         l1_in_ready, l1_out_valid, l1_out_last, l1_busy;
    logic         l16_in_ready, l16_out_valid, l16_out_last, l16_busy;
    logic [127:0] l1_out_data, l16_out_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [127:0] data;
        logic         last;
        int           vcycle;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub_shift_stage #(.SBOX_LANES(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
`ifdef SUB_SHIFT_INV_EN
        .inv(inv),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy)
    );

    sub_shift_stage #(.SBOX_LANES(1)) u_l1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_valid), .in_ready(l1_in_ready),
        .in_data(s_data), .in_last(1'b0),
`ifdef SUB_SHIFT_INV_EN
        .inv(1'b0),
`endif
        .out_valid(l1_out_valid), .out_ready(1'b1),
        .out_data(l1_out_data), .out_last(l1_out_last), .busy(l1_busy)
    );

    sub_shift_stage #(.SBOX_LANES(16)) u_l16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_valid), .in_ready(l16_in_ready),
        .in_data(s_data), .in_last(1'b0),
`ifdef SUB_SHIFT_INV_EN
        .inv(1'b0),
`endif
        .out_valid(l16_out_valid), .out_ready(1'b1),
        .out_data(l16_out_data), .out_last(l16_out_last), .busy(l16_busy)
    );

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Monitor: compares whatever the DUT presents against the queue head
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else if (out_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got %0h expected no output", out_data);
            end else begin
                if (!prev_valid) begin
                    chk("latency_cycle", 128'(cyc), 128'(sb_q[0].vcycle));
                    chk("out_last", 128'(out_last), 128'(sb_q[0].last));
                end
                chk("out_data", out_data, sb_q[0].data);
                if (out_ready) void'(sb_q.pop_front());
            end
            prev_valid = 1'b1;
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Present one block, wait (bounded) for acceptance, log its expectation
    task automatic send(input logic [127:0] d, input logic last,
                        input logic [127:0] expd);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
            return;
        end
        sb_q.push_back('{data: expd, last: last, vcycle: cyc + 1 + int'(NCH)});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited = 0;
        while (sb_q.size() != 0 && waited < 100) begin
            @(negedge clk);
            #3;
            waited++;
        end
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat1, lat16;
        logic [127:0] d1, d16;
        int waited;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
`ifdef SUB_SHIFT_INV_EN
        inv       = 1'b0;
`endif

        // Reset values
        #3;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Basic vectors
        send(ZERO_IN, 1'b0, ZERO_OUT);
        drain();
        send(APPB_IN, 1'b0, APPB_OUT);
        drain();
        send(SEQ_IN, 1'b1, SEQ_OUT);
        drain();

        // Back-to-back: second block taken on the hand-off edge
        send(ZERO_IN, 1'b1, ZERO_OUT);
        send(APPB_IN, 1'b0, APPB_OUT);
        drain();

        // Backpressure: hold 6 cycles with a competing in_valid
        @(negedge clk);
        out_ready = 1'b0;
        send(APPB_IN, 1'b0, APPB_OUT);
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("bp_reach_hold", 128'(out_valid), 128'(1));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = SEQ_IN;
            in_last  = 1'b1;
            #1;
            chk("bp_in_ready", 128'(in_ready), 128'(0));
            chk("bp_busy", 128'(busy), 128'(1));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("handoff_in_ready", 128'(in_ready), 128'(1));
        sb_q.push_back('{data: SEQ_OUT, last: 1'b1, vcycle: cyc + 1 + int'(NCH)});
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset during the second SUB cycle
        send(ZERO_IN, 1'b1, ZERO_OUT);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_out_data", out_data, 128'h0);
        chk("midrst_out_last", 128'(out_last), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(ZERO_IN, 1'b0, ZERO_OUT);
        drain();

        // Lane sweep: SBOX_LANES=1 and 16 on the same vector
        lat1  = -1;
        lat16 = -1;
        d1    = '0;
        d16   = '0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = APPB_IN;
        @(posedge clk);
        #1 s_valid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk);
            #1;
            if (l1_out_valid && lat1 < 0) begin
                lat1 = k;
                d1   = l1_out_data;
            end
            if (l16_out_valid && lat16 < 0) begin
                lat16 = k;
                d16   = l16_out_data;
            end
        end
        chk("l1_latency", 128'(lat1), 128'(16));
        chk("l1_out_data", d1, APPB_OUT);
        chk("l16_latency", 128'(lat16), 128'(1));
        chk("l16_out_data", d16, APPB_OUT);

`ifdef SUB_SHIFT_INV_EN
        // Inverse path
        inv = 1'b1;
        send(APPB_OUT, 1'b0, APPB_IN);
        drain();
        inv = 1'b0;
        send(APPB_IN, 1'b0, APPB_OUT);
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
